pc_fetch_ctrl: RTL and testbench

Parametrised program-counter controller for the RISC-V core front end. It holds the architectural fetch PC, drives a valid/ready request to instruction memory, and selects the next PC. Next-PC sources, in priority order: trap vector, branch/jump redirect, stall hold, sequential increment. It also sequences boot and debug halt/resume with a small FSM.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_next_sel.sv | 56 +++++
 rtl/pc_fetch_ctrl.sv | 99 +++++++++
 tb/tb_pc_fetch_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch PC controller.
// The optional PC_ALIGN_CHECK_EN build uses align_mask() to find misaligned targets.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_TRAP  = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_HOLD  = 2'd2,
    SEL_SEQ   = 2'd3
  } pc_sel_e;

  localparam int unsigned XLEN_DEF         = 32;
  localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR_DEF  = 32'h0000_0100;
  localparam int unsigned INC_DEF          = 4;

  // Low PC bits that must be zero for a fetch of the given increment.
  function automatic logic [1:0] align_mask(input int unsigned inc);
    return (inc == 4) ? 2'b11 : 2'b01;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux: trap, redirect, stall hold, sequential.
// With PC_ALIGN_CHECK_EN a misaligned redirect target is replaced by the trap vector.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN        = XLEN_DEF,
  parameter logic [XLEN-1:0] TRAP_VECTOR = XLEN'(TRAP_VECTOR_DEF),
  parameter int unsigned     INC         = INC_DEF
) (
  input  logic            active_i,
  input  logic            trap_valid_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            stall_i,
  input  logic            fire_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_seq_i,
  output pc_sel_e         sel_o,
  output logic [XLEN-1:0] pc_next_o
);

  always_comb begin
    sel_o = SEL_HOLD;
    if (active_i) begin
      if (trap_valid_i) begin
        sel_o = SEL_TRAP;
      end else if (redirect_valid_i) begin
`ifdef PC_ALIGN_CHECK_EN
        if (|(redirect_target_i[1:0] & align_mask(INC))) begin
          sel_o = SEL_TRAP;
        end else begin
          sel_o = SEL_REDIR;
        end
`else
        sel_o = SEL_REDIR;
`endif
      end else if (stall_i) begin
        sel_o = SEL_HOLD;
      end else if (fire_i) begin
        sel_o = SEL_SEQ;
      end
    end
  end

  always_comb begin
    pc_next_o = pc_i;
    unique case (sel_o)
      SEL_TRAP:  pc_next_o = TRAP_VECTOR;
      SEL_REDIR: pc_next_o = redirect_target_i;
      SEL_SEQ:   pc_next_o = pc_seq_i;
      SEL_HOLD:  pc_next_o = pc_i;
      default:   pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Front-end fetch PC register, imem valid/ready request and boot/halt FSM.
// Define PC_ALIGN_CHECK_EN to trap misaligned redirect targets and pulse misaligned.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEF),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(TRAP_VECTOR_DEF),
  parameter int unsigned     INC          = INC_DEF
) (
  input  logic            clk,
  input  logic            res,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic            halt_req,
  input  logic            resume,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_seq,
  output logic            halted,
  output logic            misaligned
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  pc_sel_e         sel;

  assign pc_out = pc_q;
  assign pc_seq = pc_q + XLEN'(INC);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = halt_req ? HALT : RUN;
      RUN:     if (halt_req) state_d = HALT;
      HALT:    if (resume && !halt_req) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_comb begin
    fetch_valid = (state_q == RUN) && !stall;
    halted      = (state_q == HALT);
  end

  pc_next_sel #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR),
    .INC         (INC)
  ) u_next_sel (
    .active_i          (state_q != BOOT),
    .trap_valid_i      (trap_valid),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .stall_i           (stall),
    .fire_i            (fetch_valid && fetch_ready),
    .pc_i              (pc_q),
    .pc_seq_i          (pc_seq),
    .sel_o             (sel),
    .pc_next_o         (pc_d)
  );

`ifdef PC_ALIGN_CHECK_EN
  logic misaligned_q, misaligned_d;

  // A trap select without trap_valid can only come from a misaligned redirect.
  always_comb begin
    misaligned_d = (sel == SEL_TRAP) && !trap_valid;
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign misaligned = misaligned_q;
`else
  logic unused_sel;
  assign unused_sel = ^sel;
  assign misaligned = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed plan steps, then random stimulus
// checked against a behavioural next-PC/mode model.
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_V  = 32'h0000_0000;
  localparam logic [31:0] TRAP_V = 32'h0000_0100;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res;
  logic        stall, redirect_valid, trap_valid, halt_req, resume, fetch_ready;
  logic [31:0] redirect_target;
  logic        fetch_valid, halted, misaligned;
  logic [31:0] pc_out, pc_seq;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: mode 0 = boot, 1 = run, 2 = halt.
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_mis;

  always #5 clk = ~clk;

  pc_fetch_ctrl dut (
    .clk             (clk),
    .res             (res),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_valid      (trap_valid),
    .halt_req        (halt_req),
    .resume          (resume),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .pc_out          (pc_out),
    .pc_seq          (pc_seq),
    .halted          (halted),
    .misaligned      (misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = RST_V;
    m_mode = 0;
    m_mis  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, ".pc"}, pc_out, m_pc);
    chk({tag, ".seq"}, pc_seq, m_pc + 32'd4);
    chk({tag, ".fv"}, {31'd0, fetch_valid}, {31'd0, (m_mode == 1) && !stall});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_mode == 2});
    chk({tag, ".mis"}, {31'd0, misaligned}, {31'd0, m_mis});
  endtask

  // Advance one clock, applying the next-PC and mode rules to the model.
  task automatic tick();
    logic [31:0] pc_n;
    int          mode_n;
    bit          mis_n;
    bit          fv;
    fv     = (m_mode == 1) && !stall;
    pc_n   = m_pc;
    mis_n  = 1'b0;
    mode_n = m_mode;
    if (m_mode != 0) begin
      if (trap_valid) pc_n = TRAP_V;
      else if (redirect_valid) begin
        if (ALIGN && redirect_target[1:0] != 2'b00) begin
          pc_n  = TRAP_V;
          mis_n = 1'b1;
        end else begin
          pc_n = redirect_target;
        end
      end else if (stall) pc_n = m_pc;
      else if (fv && fetch_ready) pc_n = m_pc + 32'd4;
    end
    if (m_mode == 0) mode_n = halt_req ? 2 : 1;
    else if (m_mode == 1) mode_n = halt_req ? 2 : 1;
    else mode_n = (resume && !halt_req) ? 1 : 2;
    @(posedge clk);
    m_pc   = pc_n;
    m_mode = mode_n;
    m_mis  = mis_n;
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; trap_valid = 0; halt_req = 0; resume = 0;
    fetch_ready = 0; redirect_target = 32'h0;
  endtask

  initial begin
    idle_inputs();
    res = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_all("reset");
    chk("reset.pc_lit", pc_out, RST_V);

    // Boot then sequential fetch
    res = 1'b0;
    fetch_ready = 1'b1;
    check_all("boot");
    chk("boot.fv_lit", {31'd0, fetch_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("seq");
      chk("seq.pc_lit", pc_out, 32'(i * 4));
    end
    tick();
    chk("seq.pc_10", pc_out, 32'h10);

    // Backpressure
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_all("bp");
      tick();
      chk("bp.hold", pc_out, 32'h10);
    end
    fetch_ready = 1'b1;
    check_all("bp_ready");
    tick();
    chk("bp.adv", pc_out, 32'h14);

    // Trap and redirect collision, then redirect under stall
    redirect_valid = 1; redirect_target = 32'h200; trap_valid = 1;
    check_all("coll");
    tick();
    trap_valid = 0; stall = 1;
    chk("coll.trap_wins", pc_out, 32'h100);
    check_all("stall_redir");
    tick();
    chk("stall_redir.pc", pc_out, 32'h200);
    check_all("stall_redir_post");
    stall = 0;

    // Halt and resume at 0x20
    redirect_target = 32'h20;
    tick();
    redirect_valid = 0; fetch_ready = 0; halt_req = 1;
    check_all("pre_halt");
    tick();
    fetch_ready = 1;
    for (int i = 0; i < 2; i++) begin
      check_all("halt");
      chk("halt.halted", {31'd0, halted}, 32'd1);
      chk("halt.pc", pc_out, 32'h20);
      tick();
    end
    halt_req = 0; resume = 1;
    check_all("resume");
    tick();
    resume = 0;
    check_all("resumed");
    chk("resumed.pc", pc_out, 32'h20);
    chk("resumed.fv", {31'd0, fetch_valid}, 32'd1);

    // Wrap
    redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 0;
    check_all("wrap_pre");
    chk("wrap.seq", pc_seq, 32'h0);
    tick();
    check_all("wrap");
    chk("wrap.pc", pc_out, 32'h0);

    // Alignment
    redirect_valid = 1; redirect_target = 32'h202;
    tick();
    redirect_valid = 0; fetch_ready = 0;
    check_all("align");
    chk("align.pc", pc_out, ALIGN ? 32'h100 : 32'h202);
    chk("align.mis", {31'd0, misaligned}, {31'd0, ALIGN});
    tick();
    check_all("align_post");
    chk("align_post.mis", {31'd0, misaligned}, 32'd0);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      stall           = ($urandom_range(0, 99) < 20);
      trap_valid      = ($urandom_range(0, 99) < 5);
      redirect_valid  = ($urandom_range(0, 99) < 15);
      redirect_target = $urandom;
      if ($urandom_range(0, 99) < 85) redirect_target[1:0] = 2'b00;
      halt_req        = ($urandom_range(0, 99) < 8);
      resume          = ($urandom_range(0, 99) < 30);
      fetch_ready     = ($urandom_range(0, 99) < 70);
      check_all("rnd");
      tick();
    end

    // Async reset in the middle of a stall
    idle_inputs();
    check_all("pre_rst");
    if (m_mode == 2) begin
      resume = 1;
      tick();
      resume = 0;
    end
    redirect_valid = 1; redirect_target = 32'h300;
    tick();
    redirect_valid = 0; stall = 1;
    chk("pre_rst.pc", pc_out, 32'h300);
    #2;
    res = 1'b1;
    #1;
    model_reset();
    chk("async_rst.pc", pc_out, RST_V);
    chk("async_rst.fv", {31'd0, fetch_valid}, 32'd0);
    chk("async_rst.halted", {31'd0, halted}, 32'd0);
    chk("async_rst.seq", pc_seq, RST_V + 32'd4);
    @(posedge clk);
    #1;
    check_all("in_rst");
    res = 1'b0; stall = 0; fetch_ready = 1;
    check_all("reboot");
    tick();
    check_all("reboot_run");
    tick();
    check_all("reboot_seq");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
